// File: rtl/e203_nn_dot_seq.sv
// Sequential int16x2 dot-product engine: streams word pairs from weight/image RAMs,
// accumulates lane products, writes one 32-bit result. Define E203_NN_DOT_SAT_EN for saturating accumulation.
module e203_nn_dot_seq #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_x_base,
  input  logic [ADDR_W-1:0] cfg_o_addr,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [31:0]       w_rdata,
  input  logic [31:0]       x_rdata,
  output logic              o_we,
  input  logic              o_gnt,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_e;

  state_e               state_q;
  logic [ADDR_W:0]      len_q;
  logic [ADDR_W:0]      cnt_q;
  logic [ADDR_W-1:0]    w_base_q;
  logic [ADDR_W-1:0]    x_base_q;
  logic [ADDR_W-1:0]    o_addr_q;
  logic                 vld_q;
  logic signed [31:0]   acc_q;
  logic signed [31:0]   acc_d;
  logic signed [15:0]   w_lo, w_hi, x_lo, x_hi;
  logic signed [31:0]   p_lo, p_hi;
  logic                 issue;
  logic                 last_issue;

  assign issue      = (state_q == RUN) && rd_gnt;
  assign last_issue = (cnt_q + (ADDR_W+1)'(1)) == len_q;

  // Lane products of the pair returned one cycle after its issue.
  assign w_lo = w_rdata[15:0];
  assign w_hi = w_rdata[31:16];
  assign x_lo = x_rdata[15:0];
  assign x_hi = x_rdata[31:16];
  assign p_lo = 32'(w_lo) * 32'(x_lo);
  assign p_hi = 32'(w_hi) * 32'(x_hi);

`ifdef E203_NN_DOT_SAT_EN
  logic signed [33:0] sum_full;
  assign sum_full = 34'(acc_q) + 34'(p_lo) + 34'(p_hi);

  // Clamp whenever the exact sum does not fit in 32 signed bits.
  always_comb begin
    acc_d = sum_full[31:0];
    if ((sum_full[33:31] != 3'b000) && (sum_full[33:31] != 3'b111)) begin
      acc_d = sum_full[33] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end
`else
  assign acc_d = acc_q + p_lo + p_hi;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      o_addr_q <= '0;
      vld_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      vld_q <= issue;
      if (vld_q) begin
        acc_q <= acc_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q    <= cfg_len;
            w_base_q <= cfg_w_base;
            x_base_q <= cfg_x_base;
            o_addr_q <= cfg_o_addr;
            cnt_q    <= '0;
            acc_q    <= '0;
            state_q  <= (cfg_len == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            cnt_q <= cnt_q + (ADDR_W+1)'(1);
            if (last_issue) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: state_q <= WRITE;
        WRITE: begin
          if (o_gnt) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign rd_req  = (state_q == RUN);
  assign w_addr  = w_base_q + cnt_q[ADDR_W-1:0];
  assign x_addr  = x_base_q + cnt_q[ADDR_W-1:0];
  assign o_we    = (state_q == WRITE);
  assign o_addr  = o_addr_q;
  assign o_wdata = acc_q;
  assign done    = (state_q == WRITE) && o_gnt;

endmodule

// File: tb/tb_e203_nn_dot_seq.sv
// Directed testbench for e203_nn_dot_seq with behavioural weight/image RAMs.
module tb_e203_nn_dot_seq;

  localparam int unsigned ADDR_W = 12;
`ifdef E203_NN_DOT_SAT_EN
  localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] OVF_EXP = 32'hFFFC_0004;
`endif

  logic              clk = 1'b0;
  logic              rst, start, rd_gnt, o_gnt;
  logic [ADDR_W:0]   cfg_len;
  logic [ADDR_W-1:0] cfg_w_base, cfg_x_base, cfg_o_addr;
  logic              busy, done, rd_req, o_we;
  logic [ADDR_W-1:0] w_addr, x_addr, o_addr;
  logic [31:0]       w_rdata, x_rdata, o_wdata;

  int errors = 0;
  int checks = 0;

  logic [31:0]       wmem [4096];
  logic [31:0]       xmem [4096];
  int                issue_cnt = 0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] wlog [$];
  logic [ADDR_W-1:0] xlog [$];

  e203_nn_dot_seq #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_o_addr(cfg_o_addr),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .w_addr(w_addr), .x_addr(x_addr), .w_rdata(w_rdata), .x_rdata(x_rdata),
    .o_we(o_we), .o_gnt(o_gnt), .o_addr(o_addr), .o_wdata(o_wdata)
  );

  always #5 clk = ~clk;

  // RAMs with one-cycle read latency; garbage on the data bus when nothing was issued.
  always @(posedge clk) begin
    if (rd_req && rd_gnt) begin
      w_rdata   <= wmem[w_addr];
      x_rdata   <= xmem[x_addr];
      issue_cnt <= issue_cnt + 1;
      wlog.push_back(w_addr);
      xlog.push_back(x_addr);
    end else begin
      w_rdata <= $urandom;
      x_rdata <= $urandom;
    end
    if (o_we && o_gnt) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= o_addr;
      wr_data <= o_wdata;
    end
  end

  function automatic int dot_model(int wb, int xb, int len);
    int s = 0;
    logic [31:0] w, x;
    for (int i = 0; i < len; i++) begin
      w = wmem[(wb + i) % 4096];
      x = xmem[(xb + i) % 4096];
      s += int'($signed(w[15:0])) * int'($signed(x[15:0]))
         + int'($signed(w[31:16])) * int'($signed(x[31:16]));
    end
    return s;
  endfunction

  // Launch one job, scramble cfg afterwards, count cycles from accept to done.
  task automatic run_job(input logic [ADDR_W:0] len, input logic [ADDR_W-1:0] wb,
                         input logic [ADDR_W-1:0] xb, input logic [ADDR_W-1:0] oa,
                         input bit toggle, input bit poke, output int lat, output logic busy_after);
    @(negedge clk);
    cfg_len = len; cfg_w_base = wb; cfg_x_base = xb; cfg_o_addr = oa;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_len = 13'd5; cfg_w_base = ~wb; cfg_x_base = ~xb; cfg_o_addr = ~oa;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      rd_gnt = toggle ? (k % 2 == 0) : 1'b1;
      if (poke && k == 2) start = 1'b1;
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    rd_gnt = 1'b1;
    @(negedge clk);
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rd_gnt = 1'b1; o_gnt = 1'b1;
    cfg_len = '0; cfg_w_base = '0; cfg_x_base = '0; cfg_o_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
    checks++; if (o_we !== 1'b0)   begin errors++; $display("FAIL reset_o_we got=%b exp=0", o_we); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lat, i0, w0; logic ba;
    i0 = issue_cnt; w0 = wr_cnt;
    run_job(13'd1, 12'h010, 12'h020, 12'h0AB, 1'b0, 1'b0, lat, ba);
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", lat); end
    checks++; if (wr_data !== 32'h0000_5FD7) begin errors++; $display("FAIL single_data got=%h exp=00005fd7", wr_data); end
    checks++; if (wr_addr !== 12'h0AB) begin errors++; $display("FAIL single_addr got=%h exp=0ab", wr_addr); end
    checks++; if (issue_cnt - i0 !== 1) begin errors++; $display("FAIL single_issues got=%0d exp=1", issue_cnt - i0); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL single_writes got=%0d exp=1", wr_cnt - w0); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_zero_len();
    int lat, i0; logic ba;
    i0 = issue_cnt;
    run_job(13'd0, 12'h010, 12'h020, 12'h123, 1'b0, 1'b0, lat, ba);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency got=%0d exp=2", lat); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL zero_data got=%h exp=0", wr_data); end
    checks++; if (wr_addr !== 12'h123) begin errors++; $display("FAIL zero_addr got=%h exp=123", wr_addr); end
    checks++; if (issue_cnt - i0 !== 0) begin errors++; $display("FAIL zero_issues got=%0d exp=0", issue_cnt - i0); end
  endtask

  task automatic test_toggle_grant();
    int lat_full, lat_tog, i0, q0, bad; int exp_sum; logic ba;
    exp_sum = dot_model(12'h300, 12'h400, 16);
    run_job(13'd16, 12'h300, 12'h400, 12'h050, 1'b0, 1'b0, lat_full, ba);
    checks++; if (lat_full !== 18) begin errors++; $display("FAIL full_latency got=%0d exp=18", lat_full); end
    checks++; if (wr_data !== 32'(exp_sum)) begin errors++; $display("FAIL full_data got=%h exp=%h", wr_data, 32'(exp_sum)); end
    i0 = issue_cnt; q0 = wlog.size();
    run_job(13'd16, 12'h300, 12'h400, 12'h051, 1'b1, 1'b0, lat_tog, ba);
    checks++; if (lat_tog !== 34) begin errors++; $display("FAIL toggle_latency got=%0d exp=34", lat_tog); end
    checks++; if (issue_cnt - i0 !== 16) begin errors++; $display("FAIL toggle_issues got=%0d exp=16", issue_cnt - i0); end
    checks++; if (wr_data !== 32'(exp_sum)) begin errors++; $display("FAIL toggle_data got=%h exp=%h", wr_data, 32'(exp_sum)); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (q0 + i >= wlog.size()) bad++;
      else if (wlog[q0+i] !== 12'(12'h300 + i) || xlog[q0+i] !== 12'(12'h400 + i)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_addrs bad=%0d exp=0", bad); end
  endtask

  task automatic test_overflow();
    int lat; logic ba;
    run_job(13'd2, 12'h100, 12'h200, 12'h077, 1'b0, 1'b0, lat, ba);
    checks++; if (wr_data !== OVF_EXP) begin errors++; $display("FAIL overflow_data got=%h exp=%h", wr_data, OVF_EXP); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL overflow_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_addr_wrap_and_busy_start();
    int lat, i0, q0, bad; logic ba;
    logic [ADDR_W-1:0] exp_w [4];
    exp_w[0] = 12'hFFE; exp_w[1] = 12'hFFF; exp_w[2] = 12'h000; exp_w[3] = 12'h001;
    i0 = issue_cnt; q0 = wlog.size();
    run_job(13'd4, 12'hFFE, 12'h005, 12'h060, 1'b0, 1'b1, lat, ba);
    checks++; if (lat !== 6) begin errors++; $display("FAIL wrap_latency got=%0d exp=6", lat); end
    checks++; if (issue_cnt - i0 !== 4) begin errors++; $display("FAIL wrap_issues got=%0d exp=4", issue_cnt - i0); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (q0 + i >= wlog.size()) bad++;
      else if (wlog[q0+i] !== exp_w[i] || xlog[q0+i] !== 12'(12'h005 + i)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_addrs bad=%0d exp=0", bad); end
    checks++; if (wr_data !== 32'(dot_model(12'hFFE, 12'h005, 4))) begin errors++; $display("FAIL wrap_data got=%h exp=%h", wr_data, 32'(dot_model(12'hFFE, 12'h005, 4))); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL wrap_busy_after got=%b exp=0", ba); end
  endtask

  task automatic test_reset_mid_run();
    int w0, lat; logic ba;
    @(negedge clk);
    cfg_len = 13'd16; cfg_w_base = 12'h300; cfg_x_base = 12'h400; cfg_o_addr = 12'h0EE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    w0 = wr_cnt;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL midrst_rd_req got=%b exp=0", rd_req); end
    checks++; if (o_we !== 1'b0)   begin errors++; $display("FAIL midrst_o_we got=%b exp=0", o_we); end
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL midrst_no_write got=%0d exp=0", wr_cnt - w0); end
    run_job(13'd1, 12'h010, 12'h020, 12'h0AC, 1'b0, 1'b0, lat, ba);
    checks++; if (lat !== 3) begin errors++; $display("FAIL midrst_rerun_latency got=%0d exp=3", lat); end
    checks++; if (wr_data !== 32'h0000_5FD7 || wr_addr !== 12'h0AC) begin
      errors++; $display("FAIL midrst_rerun_result got=%h@%h exp=00005fd7@0ac", wr_data, wr_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      wmem[i] = {16'(i % 97) - 16'd48, 16'(i % 61) - 16'd30};
      xmem[i] = {16'(i % 43) - 16'd21, 16'(i % 89) - 16'd44};
    end
    wmem[12'h010] = 32'h005A_00CD;
    xmem[12'h020] = 32'h00A1_0031;
    wmem[12'h100] = 32'h7FFF_7FFF; wmem[12'h101] = 32'h7FFF_7FFF;
    xmem[12'h200] = 32'h7FFF_7FFF; xmem[12'h201] = 32'h7FFF_7FFF;

    test_reset();
    test_single();
    test_zero_len();
    test_toggle_grant();
    test_overflow();
    test_addr_wrap_and_busy_start();
    test_reset_mid_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
